// File: rtl/motor_pwm_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_pwm_drv_pkg
// Description : Shared definitions for the H-bridge PWM driver.
//               - Drive-state encoding (RUN/STOP/DEAD/BRAKE).
//               - PWM period derived from the command width.
//               - The two-or-more-copies-faulty predicate, kept here so a
//                 future fault supervisor uses exactly the same rule.
// Revision    : 1.0 - initial release
// ============================================================================
package motor_pwm_drv_pkg;

    // Encoding is visible on state_o, so the values are fixed.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STOP  = 2'd1,
        ST_DEAD  = 2'd2,
        ST_BRAKE = 2'd3
    } state_t;

    // Full-scale command equals the number of ticks per PWM period, so the
    // largest command yields 100% duty.
    function automatic int period_of(input int cmd_w);
        return (1 << cmd_w) - 1;
    endfunction

    // True when at least two TMR copies are flagged: the voter can no
    // longer mask the disagreement and the drive must not be trusted.
    function automatic logic fault_multi(input logic [2:0] f);
        return (f[0] & f[1]) | (f[0] & f[2]) | (f[1] & f[2]);
    endfunction

    // States in which the bridge legs may be energised.
    function automatic logic is_drive(input state_t s);
        return (s == ST_RUN) || (s == ST_STOP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/motor_pwm_drv_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : motor_pwm_drv_pwm_gen
// Description : PWM timebase. A prescaler divides clk into ticks, a period
//               counter steps once per tick through 0..PER-1, and the
//               compare against the latched duty gives the raw PWM level.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               clr           - hold prescaler and period counter at 0
//               latch_en      - load latch_val into the duty register
//               latch_val     - duty value to load
//               pwm           - combinational compare cnt < duty
//               eop           - last clk of the current PWM period
// Revision    : 1.0 - initial release
// ============================================================================
module motor_pwm_drv_pwm_gen
    import motor_pwm_drv_pkg::*;
#(
    parameter int CMD_L   = 4,
    parameter int PWM_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             latch_en,
    input  logic [CMD_L-1:0] latch_val,
    output logic             pwm,
    output logic             eop
);

    localparam int PER  = period_of(CMD_L);
    localparam int PD_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PD_W-1:0]  PRESC_LAST = PD_W'(PWM_DIV - 1);
    localparam logic [CMD_L-1:0] CNT_LAST   = CMD_L'(PER - 1);

    logic [PD_W-1:0]  presc;
    logic [CMD_L-1:0] cnt;
    logic [CMD_L-1:0] duty_l;
    logic             tick;

    assign tick = (presc == PRESC_LAST);
    // eop is deliberately not gated by clr: the top derives clr from the
    // next state, which itself depends on eop.
    assign eop  = tick && (cnt == CNT_LAST);
    assign pwm  = (cnt < duty_l);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (clr || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_l <= '0;
        end else if (latch_en) begin
            duty_l <= latch_val;
        end
    end

endmodule
`default_nettype wire

// File: rtl/motor_pwm_drv.sv
`default_nettype none
// ============================================================================
// Module      : motor_pwm_drv
// Description : H-bridge gate driver behind the DTMR majority voter.
//               Converts the voted speed command to PWM on the leg selected
//               by the current direction, sequences reversals through a
//               finish-period STOP and a DEAD gap, and brakes whenever two
//               or more TMR copies are flagged faulty.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               speed_cmd     - voted speed magnitude
//               dir_cmd       - voted direction, MSB only (1 = reverse)
//               fault         - per-copy fault flags
//               pwm_o         - registered raw PWM
//               leg_a_o       - forward leg gate
//               leg_b_o       - reverse leg gate
//               brake_o       - high while braking
//               state_o       - RUN=0, STOP=1, DEAD=2, BRAKE=3
// Revision    : 1.0 - initial release
// ============================================================================
module motor_pwm_drv
    import motor_pwm_drv_pkg::*;
#(
    parameter int CMD_L    = 4,
    parameter int PWM_DIV  = 4,
    parameter int DEAD_T   = 8,
    parameter int BRK_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_L-1:0] speed_cmd,
    input  logic [CMD_L-1:0] dir_cmd,
    input  logic [2:0]       fault,
    output logic             pwm_o,
    output logic             leg_a_o,
    output logic             leg_b_o,
    output logic             brake_o,
    output logic [1:0]       state_o
);

    localparam int DT_W = $clog2(DEAD_T + 1);
    localparam int HD_W = $clog2(BRK_HOLD + 1);
    localparam logic [DT_W-1:0] DEAD_LAST = DT_W'(DEAD_T - 1);
    localparam logic [HD_W-1:0] HOLD_LAST = HD_W'(BRK_HOLD - 1);

    state_t           state;
    state_t           nxt;
    logic [DT_W-1:0]  dead_cnt;
    logic [HD_W-1:0]  hold_cnt;
    logic             cur_dir;
    logic             dir_req;
    logic             fault_hi;
    logic             dead_last;
    logic             hold_done;
    logic             drive_keep;
    logic             gen_clr;
    logic             gen_latch_en;
    logic [CMD_L-1:0] gen_latch_val;
    logic             gen_pwm;
    logic             gen_eop;
    logic             dir_lsbs_unused;

    assign dir_req         = dir_cmd[CMD_L-1];
    assign dir_lsbs_unused = ^dir_cmd;
    assign fault_hi        = fault_multi(fault);
    assign dead_last       = (state == ST_DEAD) && (dead_cnt == DEAD_LAST);
    assign hold_done       = (state == ST_BRAKE) && (fault == 3'b000) &&
                             (hold_cnt == HOLD_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Multi-copy fault overrides everything,
    // including a reversal already in progress.
    // ------------------------------------------------------------------
    always_comb begin
        nxt = state;
        if (fault_hi) begin
            nxt = ST_BRAKE;
        end else begin
            case (state)
                ST_RUN:   if (dir_req != cur_dir) nxt = ST_STOP;
                ST_STOP:  if (gen_eop)            nxt = ST_DEAD;
                ST_DEAD:  if (dead_last)          nxt = ST_RUN;
                ST_BRAKE: if (hold_done)          nxt = ST_DEAD;
                default:                          nxt = ST_RUN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the registered state
    // ------------------------------------------------------------------
    always_comb begin
        brake_o = (state == ST_BRAKE);
        state_o = state;
    end

    // ------------------------------------------------------------------
    // Sequencing counters and direction
    // ------------------------------------------------------------------
    // Counters run only inside their own state and are zero on entry,
    // since every path into DEAD/BRAKE passes through at least one other
    // state cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dead_cnt <= '0;
        end else if (state == ST_DEAD) begin
            dead_cnt <= dead_cnt + 1'b1;
        end else begin
            dead_cnt <= '0;
        end
    end

    // Any nonzero fault bit restarts the fault-free streak.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if ((state == ST_BRAKE) && (fault == 3'b000)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end else begin
            hold_cnt <= '0;
        end
    end

    // Direction is re-sampled only at the end of the dead gap, so a
    // command that toggles back during STOP simply lands on the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_dir <= 1'b0;
        end else if (dead_last && !fault_hi) begin
            cur_dir <= dir_req;
        end
    end

    // ------------------------------------------------------------------
    // PWM timebase control
    // ------------------------------------------------------------------
    // The timebase is held at zero while off and also on the cycle that
    // leaves DEAD, so RUN starts with prescaler and counter both at 0.
    assign gen_clr = !is_drive(state) || !is_drive(nxt);

    // Duty is loaded at period end while driving (speed in RUN, zero at
    // the end of STOP) and forced to zero throughout DEAD and BRAKE.
    assign gen_latch_en  = (gen_eop && is_drive(state)) || !is_drive(state);
    assign gen_latch_val = (state == ST_RUN) ? speed_cmd : '0;

    motor_pwm_drv_pwm_gen #(
        .CMD_L   (CMD_L),
        .PWM_DIV (PWM_DIV)
    ) u_pwm_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (gen_clr),
        .latch_en  (gen_latch_en),
        .latch_val (gen_latch_val),
        .pwm       (gen_pwm),
        .eop       (gen_eop)
    );

    // ------------------------------------------------------------------
    // Registered gate drive. Gating on both current and next state keeps
    // the legs off from the very first clk of DEAD or BRAKE.
    // ------------------------------------------------------------------
    assign drive_keep = is_drive(state) && is_drive(nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_o   <= 1'b0;
            leg_a_o <= 1'b0;
            leg_b_o <= 1'b0;
        end else begin
            pwm_o   <= drive_keep && gen_pwm;
            leg_a_o <= drive_keep && gen_pwm && !cur_dir;
            leg_b_o <= drive_keep && gen_pwm &&  cur_dir;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_drv.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_pwm_drv
// Description : Randomized self-checking bench for motor_pwm_drv. A
//               behavioural model tracks the drive mode, the clk position
//               inside the PWM period, the active duty and direction, and
//               predicts every registered output each clk.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_pwm_drv;

    localparam int CMD_L    = 4;
    localparam int PWM_DIV  = 4;
    localparam int DEAD_T   = 8;
    localparam int BRK_HOLD = 16;
    localparam int PER      = 15;
    localparam int PCLK     = PER * PWM_DIV;   // clks per PWM period
    localparam int M_RUN = 0, M_STOP = 1, M_DEAD = 2, M_BRAKE = 3;

    logic             clk;
    logic             rst;
    logic [CMD_L-1:0] speed_cmd;
    logic [CMD_L-1:0] dir_cmd;
    logic [2:0]       fault;
    logic             pwm_o;
    logic             leg_a_o;
    logic             leg_b_o;
    logic             brake_o;
    logic [1:0]       state_o;

    motor_pwm_drv #(
        .CMD_L    (CMD_L),
        .PWM_DIV  (PWM_DIV),
        .DEAD_T   (DEAD_T),
        .BRK_HOLD (BRK_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .speed_cmd (speed_cmd),
        .dir_cmd   (dir_cmd),
        .fault     (fault),
        .pwm_o     (pwm_o),
        .leg_a_o   (leg_a_o),
        .leg_b_o   (leg_b_o),
        .brake_o   (brake_o),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_mode;        // drive mode
    int m_pos;         // clk index inside the PWM period
    int m_duty;        // duty applied to the current period
    int m_dir;         // direction currently driven
    int m_dead_left;   // clks of dead gap still to run
    int m_streak;      // consecutive fault-free clks while braking
    int e_pwm, e_a, e_b, e_brk, e_st;

    task automatic model_reset();
        m_mode = M_RUN; m_pos = 0; m_duty = 0; m_dir = 0;
        m_dead_left = 0; m_streak = 0;
        e_pwm = 0; e_a = 0; e_b = 0; e_brk = 0; e_st = M_RUN;
    endtask

    // Advance the model by one clk edge with the given inputs and compute
    // the outputs expected right after that edge.
    task automatic model_step(input int spd, input int dmsb, input logic [2:0] f);
        bit multi, running, period_end, keep;
        int nm;
        multi      = ($countones(f) >= 2);
        running    = (m_mode == M_RUN) || (m_mode == M_STOP);
        period_end = running && (m_pos == PCLK - 1);
        nm = m_mode;
        if (multi) nm = M_BRAKE;
        else if (m_mode == M_RUN   && dmsb != m_dir)                     nm = M_STOP;
        else if (m_mode == M_STOP  && period_end)                        nm = M_DEAD;
        else if (m_mode == M_DEAD  && m_dead_left == 1)                  nm = M_RUN;
        else if (m_mode == M_BRAKE && f == 0 && m_streak + 1 >= BRK_HOLD) nm = M_DEAD;
        keep  = running && (nm == M_RUN || nm == M_STOP);
        e_pwm = (keep && (m_pos / PWM_DIV) < m_duty) ? 1 : 0;
        e_a   = (e_pwm == 1 && m_dir == 0) ? 1 : 0;
        e_b   = (e_pwm == 1 && m_dir == 1) ? 1 : 0;
        e_st  = nm;
        e_brk = (nm == M_BRAKE) ? 1 : 0;
        if (!running)       m_duty = 0;
        else if (period_end) m_duty = (m_mode == M_RUN) ? spd : 0;
        m_pos    = keep ? (m_pos + 1) % PCLK : 0;
        m_streak = (m_mode == M_BRAKE && f == 0) ? m_streak + 1 : 0;
        if (m_mode == M_DEAD && nm == M_RUN) m_dir = dmsb;
        if (nm == M_DEAD) m_dead_left = (m_mode == M_DEAD) ? m_dead_left - 1 : DEAD_T;
        else              m_dead_left = 0;
        m_mode = nm;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_pwm"},   {7'd0, pwm_o},   8'(e_pwm));
        check({pfx, "_leg_a"}, {7'd0, leg_a_o}, 8'(e_a));
        check({pfx, "_leg_b"}, {7'd0, leg_b_o}, 8'(e_b));
        check({pfx, "_brake"}, {7'd0, brake_o}, 8'(e_brk));
        check({pfx, "_state"}, {6'd0, state_o}, 8'(e_st));
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_pwm"},   {7'd0, pwm_o},   8'd0);
        check({pfx, "_leg_a"}, {7'd0, leg_a_o}, 8'd0);
        check({pfx, "_leg_b"}, {7'd0, leg_b_o}, 8'd0);
        check({pfx, "_brake"}, {7'd0, brake_o}, 8'd0);
        check({pfx, "_state"}, {6'd0, state_o}, 8'd0);
    endtask

    // ---------------- stimulus ----------------
    int  seg_kind, seg_left, seg_age, brk_len;
    bit  blip, bounce, did_dead_rst, did_brk_rst;
    logic dmsb;

    initial begin
        rst = 1'b1; speed_cmd = '0; dir_cmd = '0; fault = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");

        rst = 1'b0;
        speed_cmd = 4'd8; dir_cmd = '0; dmsb = 1'b0;
        seg_kind = 0; seg_left = 300; seg_age = 0; brk_len = 1;
        blip = 0; bounce = 0; did_dead_rst = 0; did_brk_rst = 0;
        model_step(int'(speed_cmd), int'(dmsb), fault);

        for (int cyc = 0; cyc < 16000; cyc++) begin
            @(negedge clk);
            check_outputs("run");

            if ((m_mode == M_DEAD && !did_dead_rst) ||
                (m_mode == M_BRAKE && m_streak >= 3 && !did_brk_rst)) begin
                if (m_mode == M_DEAD) did_dead_rst = 1; else did_brk_rst = 1;
                #1 rst = 1'b1;
                #1 check_all_zero("rst_async");
                @(negedge clk);
                check_all_zero("rst_held");
                rst = 1'b0;
                model_reset();
            end

            if (seg_left == 0) begin
                seg_kind = $urandom_range(0, 2);
                seg_left = $urandom_range(150, 350);
                seg_age  = 0;
                brk_len  = $urandom_range(1, 4);
                blip     = 1'($urandom_range(0, 1));
                bounce   = ($urandom_range(0, 3) == 0);
            end
            seg_age++;
            seg_left--;

            fault = '0;
            if ($urandom_range(0, 49) == 0) speed_cmd = 4'($urandom);
            case (seg_kind)
                0: begin
                    if ($urandom_range(0, 19) == 0)
                        fault = 3'(3'b001 << $urandom_range(0, 2));
                end
                1: begin
                    if (seg_age == 1) begin
                        dmsb = ~dmsb;
                        if ($urandom_range(0, 1) == 1) speed_cmd = 4'd15;
                    end
                    if (seg_age == 20 && bounce) dmsb = ~dmsb;
                    if ($urandom_range(0, 29) == 0)
                        fault = 3'(3'b001 << $urandom_range(0, 2));
                end
                default: begin
                    if (seg_age >= 1 && seg_age <= brk_len) begin
                        case ($urandom_range(0, 3))
                            0:       fault = 3'b011;
                            1:       fault = 3'b101;
                            2:       fault = 3'b110;
                            default: fault = 3'b111;
                        endcase
                    end
                    if (blip && seg_age == brk_len + 11) fault = 3'b010;
                end
            endcase
            dir_cmd = {dmsb, 3'($urandom)};
            model_step(int'(speed_cmd), int'(dmsb), fault);
        end

        @(negedge clk);
        check_outputs("final");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
